// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, output slot plus one-entry skid.
// Latency: response accepted at edge N appears on instr in cycle N+1; stall holds the slot, and a response arriving while the slot is held goes to the skid.
module fetch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        hlt,
  input  logic        alt_pc_ctrl,
  input  logic [15:0] alt_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] pc,
  output logic        instr_vld
);

  typedef enum logic [1:0] {S_REQ, S_SKID, S_DISCARD, S_HALT} state_t;

  state_t      r_state, w_state;
  logic [15:0] r_pc_q, w_pc_q;
  logic [15:0] r_req_addr, w_req_addr;
  logic [15:0] r_instr, w_instr;
  logic [15:0] r_pc, w_pc;
  logic        r_vld, w_vld;
  logic [15:0] r_skid_instr, w_skid_instr;
  logic [15:0] r_skid_pc, w_skid_pc;
  logic        r_skid_vld, w_skid_vld;
  logic        r_halt_pend, w_halt_pend;

  logic        w_consume;
  logic        w_can_acc;
  logic [15:0] w_addr_inc;

  assign w_consume  = r_vld & ~stall;
  assign w_can_acc  = ~r_vld | w_consume;
  assign w_addr_inc = r_req_addr + 16'd1;

  assign imem_req  = rst_n & ((r_state == S_REQ) | (r_state == S_DISCARD));
  assign imem_addr = r_req_addr;
  assign instr     = r_instr;
  assign pc        = r_pc;
  assign instr_vld = r_vld;

  always_comb begin
    w_state      = r_state;
    w_pc_q       = r_pc_q;
    w_req_addr   = r_req_addr;
    w_instr      = r_instr;
    w_pc         = r_pc;
    w_vld        = r_vld;
    w_skid_instr = r_skid_instr;
    w_skid_pc    = r_skid_pc;
    w_skid_vld   = r_skid_vld;
    w_halt_pend  = r_halt_pend;

    if (r_state != S_HALT) begin
      if (hlt) begin
        w_vld      = 1'b0;
        w_skid_vld = 1'b0;
        // An unfinished memory access must still be completed before halting
        if (((r_state == S_REQ) || (r_state == S_DISCARD)) && !imem_rdy) begin
          w_state     = S_DISCARD;
          w_halt_pend = 1'b1;
        end else begin
          w_state = S_HALT;
        end
      end else if (alt_pc_ctrl) begin
        w_vld      = 1'b0;
        w_skid_vld = 1'b0;
        w_pc_q     = alt_pc;
        case (r_state)
          S_REQ: begin
            if (imem_rdy) w_req_addr = alt_pc;
            else          w_state    = S_DISCARD;
          end
          S_SKID: begin
            w_state    = S_REQ;
            w_req_addr = alt_pc;
          end
          S_DISCARD: begin
            if (imem_rdy) begin
              if (r_halt_pend) begin
                w_state = S_HALT;
              end else begin
                w_state    = S_REQ;
                w_req_addr = alt_pc;
              end
            end
          end
          default: ;
        endcase
      end else begin
        if (w_consume) w_vld = 1'b0;
        case (r_state)
          S_REQ: begin
            if (imem_rdy) begin
              if (w_can_acc) begin
                w_instr = imem_rdata;
                w_pc    = w_addr_inc;
                w_vld   = 1'b1;
              end else begin
                w_skid_instr = imem_rdata;
                w_skid_pc    = w_addr_inc;
                w_skid_vld   = 1'b1;
                w_state      = S_SKID;
              end
              w_pc_q     = w_addr_inc;
              w_req_addr = w_addr_inc;
            end
          end
          S_SKID: begin
            if (w_can_acc) begin
              w_instr    = r_skid_instr;
              w_pc       = r_skid_pc;
              w_vld      = 1'b1;
              w_skid_vld = 1'b0;
              w_state    = S_REQ;
            end
          end
          S_DISCARD: begin
            if (imem_rdy) begin
              if (r_halt_pend) begin
                w_state = S_HALT;
              end else begin
                w_state    = S_REQ;
                w_req_addr = r_pc_q;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pc_q       <= 16'h0000;
      r_req_addr   <= 16'h0000;
      r_instr      <= 16'h0000;
      r_pc         <= 16'h0000;
      r_vld        <= 1'b0;
      r_skid_instr <= 16'h0000;
      r_skid_pc    <= 16'h0000;
      r_skid_vld   <= 1'b0;
      r_halt_pend  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_pc_q       <= w_pc_q;
      r_req_addr   <= w_req_addr;
      r_instr      <= w_instr;
      r_pc         <= w_pc;
      r_vld        <= w_vld;
      r_skid_instr <= w_skid_instr;
      r_skid_pc    <= w_skid_pc;
      r_skid_vld   <= w_skid_vld;
      r_halt_pend  <= w_halt_pend;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low; one clock, no other reset source.
REQ-003 stall  input  1  consumer (IF/ID register) cannot accept this cycle.
REQ-004 hlt  input  1  halt decoded downstream; sticky effect.
REQ-005 alt_pc_ctrl  input  1  redirect request (taken branch/jump), single-cycle pulse.
REQ-006 alt_pc  input  16  redirect target word address.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  16  word address, held stable while imem_req=1 and imem_rdy=0.
REQ-009 imem_rdy  input  1  response valid; SHALL be ignored when imem_req=0.
REQ-010 imem_rdata  input  16  instruction word, valid with imem_rdy.
REQ-011 instr  output  16  fetched instruction to IF/ID.
REQ-012 pc  output  16  fetch address of instr plus 1 (next sequential PC).
REQ-013 instr_vld  output  1  instr/pc hold a valid instruction.

Function
REQ-014 Internal state: pc_q (16b next fetch addr), req_addr (16b), output slot (instr, pc, instr_vld), one-entry skid (instr, pc, valid), FSM {REQ, SKID, DISCARD, HALT}.
REQ-015 Slot is "consumed" at an edge when instr_vld=1 and stall=0; slot "can accept" when instr_vld=0 or it is consumed that edge.
REQ-016 REQ: imem_req=1, imem_addr=req_addr; on imem_rdy, if slot can accept, load slot {imem_rdata, req_addr+1, 1}, else load skid and go SKID; in both cases pc_q<=req_addr+1 and next req_addr=req_addr+1.
REQ-017 SKID: imem_req=0; when slot can accept, move skid into slot, clear skid, return to REQ next cycle.
REQ-018 Consumption with no replacement SHALL clear instr_vld; stall=1 SHALL hold instr/pc/instr_vld unchanged.
REQ-019 Address arithmetic SHALL wrap modulo 2^16 (0xFFFF+1=0x0000).
REQ-020 Redirect (alt_pc_ctrl=1, not HALT): next edge clears instr_vld and skid valid regardless of stall, pc_q<=alt_pc; from REQ with imem_rdy=0 go DISCARD, otherwise (REQ with imem_rdy=1, or SKID) go REQ with req_addr=alt_pc; same-cycle response SHALL be dropped.
REQ-021 DISCARD: imem_req=1 at old req_addr until imem_rdy; response dropped; then REQ with req_addr=pc_q; a second redirect in DISCARD updates pc_q only.
REQ-022 hlt=1 (any state): next edge clears instr_vld and skid; if a request is outstanding (REQ, imem_rdy=0) complete it as DISCARD then HALT, else HALT directly.
REQ-023 HALT: imem_req=0, instr_vld=0, alt_pc_ctrl and stall ignored; exit only via rst_n.
REQ-024 Priority at one edge: hlt > alt_pc_ctrl > imem_rdy response > consumption.
REQ-025 Fetch latency: address presented in cycle N with imem_rdy=1 SHALL appear on instr with instr_vld=1 in cycle N+1; zero-wait memory sustains one instruction per cycle when stall=0.

Reset
REQ-026 rst_n=0 SHALL immediately force: FSM=REQ, pc_q=0x0000, req_addr=0x0000, instr=0x0000, pc=0x0000, instr_vld=0, skid cleared, imem_req=0 while rst_n=0.
REQ-027 First cycle after rst_n rises: imem_req=1, imem_addr=0x0000; reset mid-transaction SHALL abandon the request without waiting for imem_rdy.

Verification
REQ-028 Reset release, imem_rdy=1 always, rdata=addr^0xA000, stall=0 -> instr 0xA000,0xA001,0xA002 in consecutive cycles, pc 0x0001,0x0002,0x0003.
REQ-029 Memory 2 wait states -> imem_addr stable for 3 cycles, one instr_vld pulse per 3 cycles, no lost or duplicated word.
REQ-030 stall=1 for 3 cycles with slot full and response arriving -> skid holds next word, imem_req=0, words delivered in order after stall drops.
REQ-031 alt_pc_ctrl with alt_pc=0x0040 while request at 0x0005 pending -> imem_req held at 0x0005 until rdy, response dropped, next request 0x0040, next valid instr pc=0x0041.
REQ-032 req_addr=0xFFFF with rdy=1 -> pc=0x0000, next imem_addr=0x0000.
REQ-033 hlt=1 then alt_pc_ctrl and stall toggling -> instr_vld=0 and imem_req=0 until rst_n; after reset fetch resumes at 0x0000.
